// File: rtl/conv_tile_accum_pkg.sv
// Shared types and defaults for the conv tile accumulator.
// State encoding, lane widths, lane slice helper, leaky slope.
package conv_tile_accum_pkg;

   localparam int DW_DEF        = 16;
   localparam int ACC_W_DEF     = 24;
   localparam int LEAKY_MUL_DEF = 3277;
   localparam int NLANE         = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_OUT   = 2'd2
   } state_t;

   // Lane c sits at [4*DW-1-c*DW -: DW], i.e. lane 0 is the MSB lane.
   function automatic int lane_lsb(input int c, input int dw);
      return (NLANE - 1 - c) * dw;
   endfunction

endpackage

// File: rtl/conv_post_lane.sv
// One output lane: bias add, arithmetic shift, leaky ReLU, saturate.
// Ports: acc (ACC_W signed), bias (DW signed) -> y (DW signed).
module conv_post_lane
   import conv_tile_accum_pkg::*;
#(
   parameter int DW        = DW_DEF,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int LEAKY_MUL = LEAKY_MUL_DEF,
   parameter int OUT_SHIFT = 0
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic signed [DW-1:0]    bias,
   output logic signed [DW-1:0]    y
);

   localparam int SW = ACC_W + 1;
   // Room for SW-bit value times a 17-bit signed multiplier.
   localparam int PW = SW + 17;

   localparam logic signed [PW-1:0] MUL_W = PW'(LEAKY_MUL);
   localparam logic signed [PW-1:0] MAXV  = (PW'(1) <<< (DW - 1)) - PW'(1);
   localparam logic signed [PW-1:0] MINV  = -MAXV - PW'(1);

   logic signed [SW-1:0] acc_w;
   logic signed [SW-1:0] bias_w;
   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] s;
   logic signed [PW-1:0] s_w;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] lk;

   assign acc_w  = signed'({acc[ACC_W-1], acc});
   assign bias_w = signed'({{(SW-DW){bias[DW-1]}}, bias});
   assign sum    = acc_w + bias_w;
   assign s      = sum >>> OUT_SHIFT;
   assign s_w    = signed'({{(PW-SW){s[SW-1]}}, s});
   assign prod   = s_w * MUL_W;

   // Negative side scaled by LEAKY_MUL/2^15, floor via arithmetic shift.
   assign lk = s[SW-1] ? (prod >>> 15) : s_w;

   always_comb begin
      y = lk[DW-1:0];
      if (lk > MAXV) begin
         y = MAXV[DW-1:0];
      end else if (lk < MINV) begin
         y = MINV[DW-1:0];
      end
   end

endmodule

// File: rtl/conv_tile_accum.sv
// Accumulates 4x4 PE tiles over several passes, post-processes, streams rows.
// Ports: clk/rst, i_start/i_num_pass/i_bias config, i_data/i_data_en beats,
// o_data/o_valid/i_ready output handshake, o_busy, sticky o_err.
module conv_tile_accum
   import conv_tile_accum_pkg::*;
#(
   parameter int DW        = DW_DEF,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int LEAKY_MUL = LEAKY_MUL_DEF,
   parameter int OUT_SHIFT = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic [7:0]      i_num_pass,
   input  logic [4*DW-1:0] i_bias,
   input  logic [4*DW-1:0] i_data,
   input  logic            i_data_en,
   output logic [4*DW-1:0] o_data,
   output logic            o_valid,
   input  logic            i_ready,
   output logic            o_busy,
   output logic            o_err
);

   localparam int RW = 4 * DW;

   state_t state;
   state_t state_nx;

   logic [7:0]    nump;
   logic [7:0]    pass_cnt;
   logic [1:0]    beat_cnt;
   logic [1:0]    row_ptr;
   logic [RW-1:0] bias_q;

   logic signed [ACC_W-1:0] acc [4][4];
   logic signed [DW-1:0]    din [4];

   logic [1:0]    sel_row;
   logic [RW-1:0] post_row;
   logic          beat_ok;
   logic          last_beat;
   logic          take;
   logic          last_row;

   assign beat_ok   = (state == S_ACCUM) && i_data_en;
   assign last_beat = beat_ok && (beat_cnt == 2'd3)
                      && (pass_cnt == nump - 8'd1);
   assign take      = (state == S_OUT) && o_valid && i_ready;
   assign last_row  = take && (row_ptr == 2'd3);
   assign o_busy    = (state == S_OUT);

   // Post path looks one row ahead: row 0 when the tile completes,
   // row_ptr+1 while streaming, so o_data can be registered.
   assign sel_row = (state == S_OUT) ? row_ptr + 2'd1 : 2'd0;

   for (genvar c = 0; c < 4; c++) begin : g_lane
      localparam int LSB = lane_lsb(c, DW);

      assign din[c] = signed'(i_data[LSB +: DW]);

      conv_post_lane #(
         .DW        (DW),
         .ACC_W     (ACC_W),
         .LEAKY_MUL (LEAKY_MUL),
         .OUT_SHIFT (OUT_SHIFT)
      ) u_post (
         .acc  (acc[sel_row][c]),
         .bias (signed'(bias_q[LSB +: DW])),
         .y    (post_row[LSB +: DW])
      );
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (i_start)   state_nx = S_ACCUM;
         S_ACCUM: if (last_beat) state_nx = S_OUT;
         S_OUT:   if (last_row)  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nump     <= '0;
         pass_cnt <= '0;
         beat_cnt <= '0;
         row_ptr  <= '0;
         bias_q   <= '0;
         o_data   <= '0;
         o_valid  <= 1'b0;
         o_err    <= 1'b0;
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               acc[r][c] <= '0;
            end
         end
      end else begin
         if (i_data_en && (state != S_ACCUM)) begin
            o_err <= 1'b1;
         end

         if ((state == S_IDLE) && i_start) begin
            nump     <= (i_num_pass == 8'd0) ? 8'd1 : i_num_pass;
            bias_q   <= i_bias;
            beat_cnt <= '0;
            pass_cnt <= '0;
         end

         if (beat_ok) begin
            for (int c = 0; c < 4; c++) begin
               if (pass_cnt == 8'd0) begin
                  acc[beat_cnt][c] <= ACC_W'(din[c]);
               end else begin
                  acc[beat_cnt][c] <= acc[beat_cnt][c] + ACC_W'(din[c]);
               end
            end
            beat_cnt <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd3) begin
               pass_cnt <= pass_cnt + 8'd1;
            end
         end

         // Row 0 is already final when beat 3 lands on row 3.
         if (last_beat) begin
            row_ptr <= '0;
            o_valid <= 1'b1;
            o_data  <= post_row;
         end

         if (take) begin
            if (last_row) begin
               o_valid <= 1'b0;
            end else begin
               row_ptr <= row_ptr + 2'd1;
               o_data  <= post_row;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_tile_accum.sv
// Directed bench for conv_tile_accum: passes, bias, leaky, saturation,
// backpressure, dropped beats and mid-tile reset.
module tb_conv_tile_accum;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [7:0]  i_num_pass;
   logic [63:0] i_bias;
   logic [63:0] i_data;
   logic        i_data_en;
   logic [63:0] o_data;
   logic        o_valid;
   logic        i_ready;
   logic        o_busy;
   logic        o_err;

   int n_cmp = 0;
   int n_bad = 0;

   conv_tile_accum dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_num_pass (i_num_pass),
      .i_bias     (i_bias),
      .i_data     (i_data),
      .i_data_en  (i_data_en),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_busy     (o_busy),
      .o_err      (o_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] np, input logic [63:0] b);
      i_start    = 1'b1;
      i_num_pass = np;
      i_bias     = b;
      step();
      i_start    = 1'b0;
   endtask

   task automatic beat(input logic [63:0] d);
      i_data    = d;
      i_data_en = 1'b1;
      step();
      i_data_en = 1'b0;
      i_data    = '0;
   endtask

   task automatic tile(input logic [63:0] r0, input logic [63:0] r1,
                       input logic [63:0] r2, input logic [63:0] r3);
      beat(r0);
      beat(r1);
      beat(r2);
      beat(r3);
   endtask

   task automatic read_row(input string tag, input logic [63:0] exp);
      int w;
      w = 0;
      while (!o_valid && w < 20) begin
         step();
         w++;
      end
      chk({tag, "_valid"}, 64'(o_valid), 64'd1);
      chk(tag, o_data, exp);
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
   endtask

   localparam logic [63:0] A  = 64'h0001_0002_0003_0004;
   localparam logic [63:0] X  = 64'hDEAD_BEEF_1234_5678;
   localparam logic [63:0] B0 = 64'h0011_0012_0013_0014;
   localparam logic [63:0] B1 = 64'h0021_0022_0023_0024;
   localparam logic [63:0] B2 = 64'h0031_0032_0033_0034;
   localparam logic [63:0] B3 = 64'h0041_0042_0043_0044;
   localparam logic [63:0] C0 = 64'h0100_0101_0102_0103;
   localparam logic [63:0] C1 = 64'h0200_0201_0202_0203;
   localparam logic [63:0] C2 = 64'h0300_0301_0302_0303;
   localparam logic [63:0] C3 = 64'h0400_0401_0402_0403;

   initial begin
      rst        = 1'b1;
      i_start    = 1'b0;
      i_num_pass = '0;
      i_bias     = '0;
      i_data     = '0;
      i_data_en  = 1'b0;
      i_ready    = 1'b0;
      step();
      step();
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_data",  o_data,       64'd0);
      chk("rst_busy",  64'(o_busy),  64'd0);
      chk("rst_err",   64'(o_err),   64'd0);
      rst = 1'b0;
      step();

      // Single pass, idle gap inside the burst.
      do_start(8'd1, 64'd0);
      beat(A);
      step();
      beat(A);
      beat(A);
      chk("sp_not_early", 64'(o_valid), 64'd0);
      beat(A);
      chk("sp_valid_lat", 64'(o_valid), 64'd1);
      chk("sp_busy", 64'(o_busy), 64'd1);
      read_row("sp_r0", A);
      read_row("sp_r1", A);
      read_row("sp_r2", A);
      read_row("sp_r3", A);
      chk("sp_done_valid", 64'(o_valid), 64'd0);
      chk("sp_done_busy", 64'(o_busy), 64'd0);

      // Three passes, bias {5, 10, -3, 0}.
      do_start(8'd3, 64'h0005_000A_FFFD_0000);
      for (int p = 0; p < 3; p++) begin
         tile(64'h0064_0007_0014_0004, A, A, A);
      end
      read_row("bias_r0", 64'h0131_001F_0039_000C);
      read_row("bias_r1", 64'h0008_0010_0006_000C);
      read_row("bias_r2", 64'h0008_0010_0006_000C);
      read_row("bias_r3", 64'h0008_0010_0006_000C);

      // Leaky and saturation, two passes.
      // lane0: -1000*3277 = -3277000, >>>15 floors to -101 (FF9B)
      // lane1: 40000 -> 7FFF; lane2: -65536 -> -6554 (E666)
      // row1: -2 -> -1, 65534 -> 7FFF, 20, -20 -> -3
      do_start(8'd2, 64'd0);
      for (int p = 0; p < 2; p++) begin
         tile(64'hFE0C_4E20_8000_0000, 64'hFFFF_7FFF_000A_FFF6,
              64'd0, 64'd0);
      end
      read_row("lk_r0", 64'hFF9B_7FFF_E666_0000);
      read_row("lk_r1", 64'hFFFF_7FFF_0014_FFFD);
      read_row("lk_r2", 64'd0);
      read_row("lk_r3", 64'd0);

      // Backpressure on row 1; num_pass 0 acts as 1.
      do_start(8'd0, 64'd0);
      tile(B0, B1, B2, B3);
      read_row("bp_r0", B0);
      for (int k = 0; k < 5; k++) begin
         chk("bp_hold_data", o_data, B1);
         chk("bp_hold_valid", 64'(o_valid), 64'd1);
         step();
      end
      read_row("bp_r1", B1);
      read_row("bp_r2", B2);
      read_row("bp_r3", B3);
      chk("bp_idle_busy", 64'(o_busy), 64'd0);
      chk("bp_idle_valid", 64'(o_valid), 64'd0);

      // Dropped beats: IDLE, start+data together, and during OUT.
      chk("err_pre", 64'(o_err), 64'd0);
      beat(X);
      chk("err_idle", 64'(o_err), 64'd1);
      i_start    = 1'b1;
      i_num_pass = 8'd1;
      i_bias     = 64'd0;
      i_data     = X;
      i_data_en  = 1'b1;
      step();
      i_start    = 1'b0;
      i_data_en  = 1'b0;
      tile(C0, C1, C2, C3);
      chk("err_tile_valid", 64'(o_valid), 64'd1);
      beat(X);
      chk("err_out", 64'(o_err), 64'd1);
      chk("err_out_data", o_data, C0);
      read_row("err_r0", C0);
      read_row("err_r1", C1);
      read_row("err_r2", C2);
      read_row("err_r3", C3);
      chk("err_sticky", 64'(o_err), 64'd1);

      // Reset after two beats of a two-pass tile.
      do_start(8'd2, 64'h0001_0001_0001_0001);
      beat(X);
      beat(X);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_valid", 64'(o_valid), 64'd0);
      chk("mr_err", 64'(o_err), 64'd0);
      chk("mr_busy", 64'(o_busy), 64'd0);
      do_start(8'd1, 64'd0);
      tile(B3, B2, B1, B0);
      read_row("mr_r0", B3);
      read_row("mr_r1", B2);
      read_row("mr_r2", B1);
      read_row("mr_r3", B0);
      chk("mr_end_valid", 64'(o_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
